// File: rtl/bits_pkg.sv
// Shared types and helpers for the BITS instruction-memory fetch path.
package bits_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READY,
    S_ISSUE,
    S_WAIT,
    S_ACK,
    S_RELEASE,
    S_DONE
  } fetch_state_e;

  localparam int BYTES_PER_WORD = 16;

  // Valid-byte mask for a word delivered with bytes_left bytes still owed.
  // Byte 15 comes first in stream order, so a partial word fills from the top.
  function automatic logic [15:0] byte_valid_mask(input logic [15:0] bytes_left);
    logic [4:0] w_shift;
    if (bytes_left >= 16'(BYTES_PER_WORD)) return 16'hFFFF;
    w_shift = 5'(BYTES_PER_WORD) - {1'b0, bytes_left[3:0]};
    return 16'hFFFF << w_shift;
  endfunction

endpackage

// File: rtl/bits_imem_fetch.sv
// Instruction-memory fetch controller: walks memory from word 0 and serves
// expectedBytes bytes as 128-bit words over a four-phase req/ack handshake.
module bits_imem_fetch
  import bits_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              resetB,
  input  logic              start,
  input  logic [15:0]       expectedBytes,
  input  logic              mem_req_b,
  output logic              mem_ack_b,
  output logic [127:0]      instruction_word,
  output logic [15:0]       instruction_byte_valid,
  output logic              done_reading_memory,
  output logic              busy,
  output logic              imem_ceb,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [127:0]      imem_rdata
);

  fetch_state_e        r_state;
  fetch_state_e        w_state_next;
  logic [15:0]         r_bytes_left;
  logic [ADDR_W-1:0]   r_addr;
  logic [2:0]          r_lat_cnt;
  logic                r_ack_b;
  logic                r_ceb;
  logic [ADDR_W-1:0]   r_imem_addr;
  logic [127:0]        r_word;
  logic [15:0]         r_mask;
  logic                r_done;
  logic                r_busy;

  logic                w_start_ok;
  logic                w_capture;
  logic [15:0]         w_bytes_after;

  // A start is honoured only when no pass is in flight.
  assign w_start_ok    = start && (r_state == S_IDLE || r_state == S_DONE);
  // The counter was loaded with MEM_LAT; reaching 1 here means this is the data cycle.
  assign w_capture     = (r_state == S_WAIT) && (r_lat_cnt == 3'd1);
  assign w_bytes_after = (r_bytes_left >= 16'(BYTES_PER_WORD))
                         ? r_bytes_left - 16'(BYTES_PER_WORD) : 16'd0;

  // Next-state decode for the fetch handshake.
  always_comb begin
    // NOTE: default assigned first so every path drives w_state_next; no latch.
    w_state_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) w_state_next = (expectedBytes == 16'd0) ? S_DONE : S_READY;
      end
      S_READY:   if (!mem_req_b) w_state_next = S_ISSUE;
      S_ISSUE:   w_state_next = S_WAIT;
      S_WAIT:    if (r_lat_cnt == 3'd1) w_state_next = S_ACK;
      S_ACK:     w_state_next = (w_bytes_after == 16'd0) ? S_DONE : S_RELEASE;
      S_RELEASE: if (mem_req_b) w_state_next = S_READY;
      default:   w_state_next = S_IDLE;
    endcase
  end

  // State register plus datapath; outputs are registered from the next state
  // so the strobes line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (resetB) begin
      // NOTE: sequential state uses non-blocking assignments throughout.
      r_state      <= S_IDLE;
      r_bytes_left <= 16'd0;
      r_addr       <= '0;
      r_lat_cnt    <= 3'd0;
      r_ack_b      <= 1'b1;
      r_ceb        <= 1'b1;
      r_imem_addr  <= '0;
      r_word       <= '0;
      r_mask       <= 16'd0;
      r_done       <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_ceb   <= (w_state_next != S_ISSUE);
      r_ack_b <= (w_state_next != S_ACK);
      r_busy  <= !(w_state_next == S_IDLE || w_state_next == S_DONE);

      if (w_start_ok) begin
        r_bytes_left <= expectedBytes;
        r_addr       <= '0;
        r_done       <= (expectedBytes == 16'd0);
      end

      if (r_state == S_READY && !mem_req_b) r_imem_addr <= r_addr;

      if (r_state == S_ISSUE)     r_lat_cnt <= 3'(MEM_LAT);
      else if (r_state == S_WAIT) r_lat_cnt <= r_lat_cnt - 3'd1;

      // Done is raised with the data so it is visible in the ack cycle.
      if (w_capture) begin
        r_word <= imem_rdata;
        r_mask <= byte_valid_mask(r_bytes_left);
        r_done <= (r_bytes_left <= 16'(BYTES_PER_WORD));
      end

      if (r_state == S_ACK) begin
        r_bytes_left <= w_bytes_after;
        r_addr       <= r_addr + ADDR_W'(1);
      end
    end
  end

  assign mem_ack_b              = r_ack_b;
  assign imem_ceb               = r_ceb;
  assign imem_addr              = r_imem_addr;
  assign instruction_word       = r_word;
  assign instruction_byte_valid = r_mask;
  assign done_reading_memory    = r_done;
  assign busy                   = r_busy;

endmodule

// File: tb/tb_bits_imem_fetch.sv
// Scoreboard bench for bits_imem_fetch: the driver pushes expected words and
// ack times, a negedge monitor pops and compares whenever an ack appears.
module tb_bits_imem_fetch;

  localparam int ADDR_W = 12;
  localparam int LAT    = 3;

  logic              clk = 1'b0;
  logic              resetB;
  logic              start;
  logic [15:0]       expectedBytes;
  logic              mem_req_b;
  logic              mem_ack_b;
  logic [127:0]      instruction_word;
  logic [15:0]       instruction_byte_valid;
  logic              done_reading_memory;
  logic              busy;
  logic              imem_ceb;
  logic [ADDR_W-1:0] imem_addr;
  logic [127:0]      imem_rdata;

  bits_imem_fetch #(.ADDR_W(ADDR_W), .MEM_LAT(LAT)) dut (
    .clk                    (clk),
    .resetB                 (resetB),
    .start                  (start),
    .expectedBytes          (expectedBytes),
    .mem_req_b              (mem_req_b),
    .mem_ack_b              (mem_ack_b),
    .instruction_word       (instruction_word),
    .instruction_byte_valid (instruction_byte_valid),
    .done_reading_memory    (done_reading_memory),
    .busy                   (busy),
    .imem_ceb               (imem_ceb),
    .imem_addr              (imem_addr),
    .imem_rdata             (imem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [127:0]      word;
    logic [15:0]       mask;
    logic              done;
  } exp_t;

  exp_t         exp_q[$];
  int           tq[$];
  int           n_checks = 0;
  int           n_fail   = 0;
  int           cyc      = 0;
  int           n_ceb    = 0;
  int           n_ack    = 0;
  int           last_ceb_cyc = 0;
  logic [ADDR_W-1:0] last_ceb_addr = '0;

  logic [127:0] mem [256];
  int           mem_cnt = 0;
  logic [7:0]   mem_a   = 8'd0;
  logic [127:0] mem_nx;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory model: data appears LAT cycles after the chip-enable cycle; any
  // other cycle carries junk so mistimed captures are visible.
  always @(posedge clk) begin
    cyc++;
    mem_nx = {$urandom, $urandom, $urandom, $urandom};
    if (mem_cnt != 0) begin
      mem_cnt--;
      if (mem_cnt == 0) mem_nx = mem[mem_a];
    end
    if (!imem_ceb) begin
      mem_a = imem_addr[7:0];
      if (LAT == 1) mem_nx = mem[mem_a];
      else mem_cnt = LAT - 1;
    end
    imem_rdata <= mem_nx;
  end

  // Monitor: compare every ack against the scoreboard.
  always @(negedge clk) begin
    if (!imem_ceb) begin
      n_ceb++;
      last_ceb_cyc  = cyc;
      last_ceb_addr = imem_addr;
    end
    if (!mem_ack_b) begin
      n_ack++;
      if (exp_q.size() == 0) begin
        check("unexpected_ack", {127'd0, mem_ack_b}, 128'd1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("fetch_addr", {116'd0, last_ceb_addr}, {116'd0, e.addr});
        check("word", instruction_word, e.word);
        check("mask", {112'd0, instruction_byte_valid}, {112'd0, e.mask});
        check("done_at_ack", {127'd0, done_reading_memory}, {127'd0, e.done});
        check("ceb_to_ack", 128'(cyc - last_ceb_cyc), 128'(LAT + 1));
        if (tq.size() != 0) check("req_to_ack", 128'(cyc), 128'(tq.pop_front()));
      end
    end
  end

  function automatic logic [15:0] ref_mask(input int rem);
    logic [15:0] m;
    m = 16'd0;
    for (int i = 0; i < 16; i++) if (i < rem) m[15-i] = 1'b1;
    return m;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ack_b"}, {127'd0, mem_ack_b}, 128'd1);
    check({tag, "_ceb"},   {127'd0, imem_ceb}, 128'd1);
    check({tag, "_addr"},  {116'd0, imem_addr}, 128'd0);
    check({tag, "_word"},  instruction_word, 128'd0);
    check({tag, "_mask"},  {112'd0, instruction_byte_valid}, 128'd0);
    check({tag, "_done"},  {127'd0, done_reading_memory}, 128'd0);
    check({tag, "_busy"},  {127'd0, busy}, 128'd0);
  endtask

  task automatic pulse_start(input int bytes);
    exp_t e;
    int   nwords;
    nwords = (bytes + 15) / 16;
    for (int n = 0; n < nwords; n++) begin
      e.addr = ADDR_W'(n);
      e.word = mem[n];
      e.mask = (bytes - 16 * n >= 16) ? 16'hFFFF : ref_mask(bytes - 16 * n);
      e.done = (n == nwords - 1);
      exp_q.push_back(e);
    end
    @(negedge clk);
    expectedBytes = 16'(bytes);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    expectedBytes = 16'($urandom);
  endtask

  // One full pass. hold_low keeps the request low after the first ack;
  // repulse fires a start with 99 bytes and drops the request during ISSUE.
  task automatic run_pass(input int bytes, input bit hold_low, input bit repulse);
    int nwords;
    int snap_ceb;
    int snap_ack;
    bit got;
    nwords = (bytes + 15) / 16;
    snap_ceb = n_ceb;
    snap_ack = n_ack;
    pulse_start(bytes);
    if (bytes == 0) begin
      check("zero_done", {127'd0, done_reading_memory}, 128'd1);
      check("zero_busy", {127'd0, busy}, 128'd0);
      mem_req_b = 1'b0;
      repeat (10) @(negedge clk);
      mem_req_b = 1'b1;
      check("zero_no_ceb", 128'(n_ceb), 128'(snap_ceb));
      check("zero_no_ack", 128'(n_ack), 128'(snap_ack));
      return;
    end
    check("start_clears_done", {127'd0, done_reading_memory}, 128'd0);
    check("start_busy", {127'd0, busy}, 128'd1);
    for (int w = 0; w < nwords; w++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      mem_req_b = 1'b0;
      tq.push_back(cyc + 2 + LAT);
      got = 1'b0;
      for (int t = 0; t < 64 && !got; t++) begin
        @(negedge clk);
        if (repulse && w == 0) begin
          if (t == 0) begin
            start = 1'b1;
            expectedBytes = 16'd99;
            mem_req_b = 1'b1;
          end else if (t == 1) begin
            start = 1'b0;
          end
        end
        if (!mem_ack_b) got = 1'b1;
      end
      check("ack_seen", {127'd0, got}, 128'd1);
      if (!got) begin
        mem_req_b = 1'b1;
        exp_q.delete();
        tq.delete();
        return;
      end
      if (hold_low && w == 0 && nwords > 1) begin
        snap_ceb = n_ceb;
        repeat (10) @(negedge clk);
        check("held_req_no_ceb", 128'(n_ceb), 128'(snap_ceb));
      end
      mem_req_b = 1'b1;
      if (w == nwords - 1) begin
        @(negedge clk);
        check("done_sticky", {127'd0, done_reading_memory}, 128'd1);
        check("busy_falls", {127'd0, busy}, 128'd0);
        check("ack_one_cycle", {127'd0, mem_ack_b}, 128'd1);
      end else begin
        repeat (2) @(negedge clk);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
    resetB        = 1'b1;
    start         = 1'b0;
    expectedBytes = 16'd0;
    mem_req_b     = 1'b1;
    repeat (3) @(negedge clk);
    resetB = 1'b0;
    check_reset_outputs("reset");

    run_pass(32, 1'b0, 1'b0);
    run_pass(20, 1'b0, 1'b0);
    run_pass(0,  1'b0, 1'b0);
    run_pass(17, 1'b0, 1'b0);
    run_pass(48, 1'b1, 1'b0);
    run_pass(40, 1'b0, 1'b1);

    // Reset during WAIT: the in-flight read must vanish.
    @(negedge clk);
    expectedBytes = 16'd48;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    mem_req_b = 1'b0;
    repeat (2) @(negedge clk);
    resetB = 1'b1;
    @(negedge clk);
    resetB = 1'b0;
    mem_req_b = 1'b1;
    check_reset_outputs("reset_in_wait");
    repeat (LAT + 4) @(negedge clk);
    run_pass(16, 1'b0, 1'b0);

    for (int k = 0; k < 10; k++) begin
      run_pass(($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 200)), 1'b0, 1'b0);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 128'(exp_q.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
